rhd2048: RTL and testbench

SPI master for a bank of 16 Intan RHD2164-class amplifier ports sharing one SCLK/MOSI/CS, each port returning DDR MISO data (two 16-bit words per frame). It runs a fixed configuration sequence, continuous recording, or one impedance-check pass, and applies per-word programmable MISO sampling delay to compensate for cable delay. Captured words stream out one per clock to downstream packing/FIFO logic.

---
 rtl/rhd2048.sv | 185 ++++++++++++++++++
 tb/tb_rhd2048.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhd2048.sv
// rtl/rhd2048.sv - SPI master for 16 RHD2164-class ports with DDR MISO capture and per-word delay
module rhd2048 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        config_start,
    input  logic        record_start,
    input  logic        zcheck_start,
    input  logic [7:0]  oversample_offset_A1, oversample_offset_A2, oversample_offset_B1, oversample_offset_B2,
    input  logic [7:0]  oversample_offset_C1, oversample_offset_C2, oversample_offset_D1, oversample_offset_D2,
    input  logic [7:0]  oversample_offset_E1, oversample_offset_E2, oversample_offset_F1, oversample_offset_F2,
    input  logic [7:0]  oversample_offset_G1, oversample_offset_G2, oversample_offset_H1, oversample_offset_H2,
    input  logic [7:0]  oversample_offset_I1, oversample_offset_I2, oversample_offset_J1, oversample_offset_J2,
    input  logic [7:0]  oversample_offset_K1, oversample_offset_K2, oversample_offset_L1, oversample_offset_L2,
    input  logic [7:0]  oversample_offset_M1, oversample_offset_M2, oversample_offset_N1, oversample_offset_N2,
    input  logic [7:0]  oversample_offset_O1, oversample_offset_O2, oversample_offset_P1, oversample_offset_P2,
    input  logic [15:0] miso,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [4:0]  data_stream,
    output logic [15:0] data_cmd,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_RECORD, S_ZCHECK} state_t;

    state_t      r_state, w_nstate;
    logic [7:0]  r_cyc, w_ncyc;
    logic [6:0]  r_idx, w_nidx, w_last;
    logic [15:0] r_cmd, w_ncmd;
    logic [5:0]  r_emit;
    logic        w_frame_end, w_nframe;
    logic [7:0]  w_off        [32];
    logic [15:0] r_shift      [32];
    logic [15:0] w_shift_next [32];
    logic [15:0] r_word       [32];

    assign w_off[0]  = oversample_offset_A1; assign w_off[1]  = oversample_offset_A2;
    assign w_off[2]  = oversample_offset_B1; assign w_off[3]  = oversample_offset_B2;
    assign w_off[4]  = oversample_offset_C1; assign w_off[5]  = oversample_offset_C2;
    assign w_off[6]  = oversample_offset_D1; assign w_off[7]  = oversample_offset_D2;
    assign w_off[8]  = oversample_offset_E1; assign w_off[9]  = oversample_offset_E2;
    assign w_off[10] = oversample_offset_F1; assign w_off[11] = oversample_offset_F2;
    assign w_off[12] = oversample_offset_G1; assign w_off[13] = oversample_offset_G2;
    assign w_off[14] = oversample_offset_H1; assign w_off[15] = oversample_offset_H2;
    assign w_off[16] = oversample_offset_I1; assign w_off[17] = oversample_offset_I2;
    assign w_off[18] = oversample_offset_J1; assign w_off[19] = oversample_offset_J2;
    assign w_off[20] = oversample_offset_K1; assign w_off[21] = oversample_offset_K2;
    assign w_off[22] = oversample_offset_L1; assign w_off[23] = oversample_offset_L2;
    assign w_off[24] = oversample_offset_M1; assign w_off[25] = oversample_offset_M2;
    assign w_off[26] = oversample_offset_N1; assign w_off[27] = oversample_offset_N2;
    assign w_off[28] = oversample_offset_O1; assign w_off[29] = oversample_offset_O2;
    assign w_off[30] = oversample_offset_P1; assign w_off[31] = oversample_offset_P2;

    function automatic logic [7:0] f_cfg_data(input logic [4:0] r);
        case (r)
            5'd0:  f_cfg_data = 8'hDE; 5'd1:  f_cfg_data = 8'h20; 5'd2:  f_cfg_data = 8'h28;
            5'd3:  f_cfg_data = 8'h02; 5'd4:  f_cfg_data = 8'hD6; 5'd5:  f_cfg_data = 8'h00;
            5'd6:  f_cfg_data = 8'h00; 5'd7:  f_cfg_data = 8'h00; 5'd8:  f_cfg_data = 8'h16;
            5'd9:  f_cfg_data = 8'h17; 5'd10: f_cfg_data = 8'hA8; 5'd11: f_cfg_data = 8'h0A;
            5'd12: f_cfg_data = 8'h2C; 5'd13: f_cfg_data = 8'h06;
            default: f_cfg_data = 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] f_cmd(input state_t st, input logic [6:0] idx);
        logic [6:0] k;
        f_cmd = 16'h0000;
        k     = 7'd0;
        case (st)
            S_CONFIG: begin
                k = idx - 7'd3;
                if (idx < 7'd3)        f_cmd = 16'hFF00;
                else if (idx < 7'd21)  f_cmd = {2'b10, k[5:0], f_cfg_data(k[4:0])};
                else if (idx == 7'd21) f_cmd = 16'h5500;
                else                   f_cmd = 16'hFF00;
            end
            S_RECORD: f_cmd = (idx < 7'd32) ? {2'b00, idx[5:0], 8'h00} : 16'hFF00;
            S_ZCHECK: begin
                // Odd frames select the channel, the following frame converts it
                k = idx - 7'd1;
                if (idx == 7'd0)       f_cmd = 16'h8541;
                else if (idx == 7'd65) f_cmd = 16'h8500;
                else if (!k[0])        f_cmd = {8'h87, 2'b00, k[6:1]};
                else                   f_cmd = {2'b00, k[6:1], 8'h00};
            end
            default: f_cmd = 16'h0000;
        endcase
    endfunction

    always_comb begin
        w_nstate = r_state;
        w_ncyc   = r_cyc;
        w_nidx   = r_idx;
        case (r_state)
            S_CONFIG: w_last = 7'd30;
            S_RECORD: w_last = 7'd34;
            default:  w_last = 7'd65;
        endcase
        if (r_state == S_IDLE) begin
            w_ncyc = 8'd0;
            w_nidx = 7'd0;
            if (config_start)      w_nstate = S_CONFIG;
            else if (zcheck_start) w_nstate = S_ZCHECK;
            else if (record_start) w_nstate = S_RECORD;
        end else if (r_cyc == 8'd151) begin
            w_ncyc = 8'd0;
            if (r_idx == w_last) begin
                w_nidx = 7'd0;
                if (r_state != S_RECORD) w_nstate = S_IDLE;
            end else begin
                w_nidx = r_idx + 7'd1;
            end
        end else begin
            w_ncyc = r_cyc + 8'd1;
        end
        w_ncmd = f_cmd(w_nstate, w_nidx);
    end

    assign w_frame_end = (r_state != S_IDLE) && (r_cyc == 8'd151);
    assign w_nframe    = (w_nstate != S_IDLE) && (w_ncyc < 8'd128);

    // Word g samples port g/2; even words strobe on sclk rise, odd on sclk fall, each delayed by its clamped offset
    for (genvar g = 0; g < 32; g++) begin : gen_cap
        logic [7:0] w_eff, w_t;
        logic       w_cap;
        assign w_eff = (w_off[g] > 8'd23) ? 8'd23 : w_off[g];
        assign w_t   = r_cyc - w_eff;
        assign w_cap = (r_state != S_IDLE) && (r_cyc >= w_eff) && (w_t < 8'd128)
                       && (w_t[2:0] == ((g % 2 == 1) ? 3'd7 : 3'd3));
        assign w_shift_next[g] = w_cap ? {r_shift[g][14:0], miso[g/2]} : r_shift[g];
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state     <= S_IDLE;
            r_cyc       <= 8'd0;
            r_idx       <= 7'd0;
            r_cmd       <= 16'h0000;
            r_emit      <= 6'd0;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            cs_n        <= 1'b1;
            busy        <= 1'b0;
            data_out    <= 16'h0000;
            data_valid  <= 1'b0;
            data_stream <= 5'd0;
            data_cmd    <= 16'h0000;
            for (int i = 0; i < 32; i++) begin
                r_shift[i] <= 16'h0000;
                r_word[i]  <= 16'h0000;
            end
        end else begin
            r_state <= w_nstate;
            r_cyc   <= w_ncyc;
            r_idx   <= w_nidx;
            r_cmd   <= w_ncmd;
            busy    <= (w_nstate != S_IDLE);
            cs_n    <= !w_nframe;
            sclk    <= w_nframe && w_ncyc[2];
            mosi    <= w_nframe && w_ncmd[4'd15 - w_ncyc[6:3]];
            for (int i = 0; i < 32; i++) begin
                r_shift[i] <= w_frame_end ? 16'h0000 : w_shift_next[i];
                if (w_frame_end) r_word[i] <= w_shift_next[i];
            end
            if (w_frame_end) begin
                data_valid  <= 1'b1;
                data_stream <= 5'd0;
                data_out    <= w_shift_next[0];
                data_cmd    <= r_cmd;
                r_emit      <= 6'd1;
            end else if (r_emit == 6'd32) begin
                data_valid <= 1'b0;
                r_emit     <= 6'd0;
            end else if (r_emit != 6'd0) begin
                data_out    <= r_word[r_emit[4:0]];
                data_stream <= r_emit[4:0];
                r_emit      <= r_emit + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_rhd2048.sv
// tb/tb_rhd2048.sv - scoreboard bench for rhd2048 command sequencing and MISO capture
module tb_rhd2048;

    logic        clk = 1'b0;
    logic        rstn, config_start, record_start, zcheck_start;
    logic [7:0]  off [32];
    logic        tb_tie, tb_loop;
    logic [15:0] miso;
    logic        sclk, mosi, cs_n, data_valid, busy;
    logic [15:0] data_out, data_cmd;
    logic [4:0]  data_stream;

    always #4 clk = ~clk;

    assign miso = {{15{tb_tie}}, tb_loop ? mosi : tb_tie};

    rhd2048 dut (
        .clk(clk), .rstn(rstn), .config_start(config_start), .record_start(record_start), .zcheck_start(zcheck_start),
        .oversample_offset_A1(off[0]),  .oversample_offset_A2(off[1]),  .oversample_offset_B1(off[2]),  .oversample_offset_B2(off[3]),
        .oversample_offset_C1(off[4]),  .oversample_offset_C2(off[5]),  .oversample_offset_D1(off[6]),  .oversample_offset_D2(off[7]),
        .oversample_offset_E1(off[8]),  .oversample_offset_E2(off[9]),  .oversample_offset_F1(off[10]), .oversample_offset_F2(off[11]),
        .oversample_offset_G1(off[12]), .oversample_offset_G2(off[13]), .oversample_offset_H1(off[14]), .oversample_offset_H2(off[15]),
        .oversample_offset_I1(off[16]), .oversample_offset_I2(off[17]), .oversample_offset_J1(off[18]), .oversample_offset_J2(off[19]),
        .oversample_offset_K1(off[20]), .oversample_offset_K2(off[21]), .oversample_offset_L1(off[22]), .oversample_offset_L2(off[23]),
        .oversample_offset_M1(off[24]), .oversample_offset_M2(off[25]), .oversample_offset_N1(off[26]), .oversample_offset_N2(off[27]),
        .oversample_offset_O1(off[28]), .oversample_offset_O2(off[29]), .oversample_offset_P1(off[30]), .oversample_offset_P2(off[31]),
        .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .data_out(data_out), .data_valid(data_valid),
        .data_stream(data_stream), .data_cmd(data_cmd), .busy(busy)
    );

    typedef struct packed {
        logic [4:0]  s;
        logic [15:0] w;
        logic [15:0] c;
    } exp_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        sb [$];
    exp_t        mon_e;
    logic [15:0] q_frames [$];
    int          q_low [$];
    logic [15:0] d_cur;
    logic        d_prev_cs, d_prev_sclk;
    int          d_lowlen, d_highlen, d_cyc, d_last_rise, last_high, period_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] cfg_data(input int r);
        case (r)
            0: return 8'hDE;  1: return 8'h20;  2: return 8'h28;  3: return 8'h02;
            4: return 8'hD6;  8: return 8'h16;  9: return 8'h17; 10: return 8'hA8;
            11: return 8'h0A; 12: return 8'h2C; 13: return 8'h06;
            5, 6, 7: return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] cfg_cmd(input int f);
        if (f < 3)   return 16'hFF00;
        if (f < 21)  return {2'b10, 6'(f - 3), cfg_data(f - 3)};
        if (f == 21) return 16'h5500;
        return 16'hFF00;
    endfunction

    function automatic logic [15:0] rec_cmd(input int f);
        int g;
        g = f % 35;
        return (g < 32) ? {2'b00, 6'(g), 8'h00} : 16'hFF00;
    endfunction

    function automatic logic [15:0] z_cmd(input int f);
        int k;
        k = f - 1;
        if (f == 0)  return 16'h8541;
        if (f == 65) return 16'h8500;
        if (k % 2 == 0) return {8'h87, 8'(k / 2)};
        return {2'b00, 6'(k / 2), 8'h00};
    endfunction

    task automatic push_frame(input logic [15:0] c, input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] wr);
        for (int s = 0; s < 32; s++)
            sb.push_back('{s: 5'(s), w: (s == 0) ? w0 : (s == 1) ? w1 : wr, c: c});
    endtask

    task automatic wait_frames(input int n, input int limit);
        int c;
        c = 0;
        while (q_frames.size() < n && c < limit) begin
            @(posedge clk);
            c++;
        end
        if (q_frames.size() < n) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_frames got=%0d exp=%0d", q_frames.size(), n);
        end
    endtask

    task automatic wait_idle(input int limit);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < limit) begin
            @(posedge clk);
            c++;
        end
        if (busy !== 1'b0) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_idle busy=%b after %0d clk", busy, c);
        end
    endtask

    task automatic pulse(input int which);
        @(posedge clk); #1;
        if (which == 0) config_start = 1'b1;
        if (which == 1) record_start = 1'b1;
        if (which == 2) zcheck_start = 1'b1;
        @(posedge clk); #1;
        config_start = 1'b0; record_start = 1'b0; zcheck_start = 1'b0;
    endtask

    // Scoreboard monitor: one expected entry per valid word
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected stream=%0d data=%h cmd=%h", data_stream, data_out, data_cmd);
            end else begin
                mon_e = sb.pop_front();
                if ({data_stream, data_out, data_cmd} !== mon_e) begin
                    n_fail++;
                    $display("FAIL sb_word got s=%0d d=%h c=%h exp s=%0d d=%h c=%h",
                             data_stream, data_out, data_cmd, mon_e.s, mon_e.w, mon_e.c);
                end
            end
        end
    end

    // SPI frame decoder: collects mosi on sclk rises, measures cs_n and sclk timing
    always @(negedge clk) begin
        d_cyc++;
        if (rstn !== 1'b0) begin
            d_prev_cs = 1'b1; d_prev_sclk = 1'b0; d_lowlen = 0; d_highlen = 0; d_cur = 16'h0;
        end else begin
            if (cs_n === 1'b0) begin
                if (d_prev_cs && q_frames.size() > 0) last_high = d_highlen;
                d_lowlen++;
            end else begin
                if (!d_prev_cs) begin
                    q_frames.push_back(d_cur);
                    q_low.push_back(d_lowlen);
                    d_lowlen  = 0;
                    d_highlen = 0;
                end
                d_highlen++;
            end
            if (sclk === 1'b1 && !d_prev_sclk) begin
                d_cur = {d_cur[14:0], mosi};
                if (d_lowlen > 8) period_in = d_cyc - d_last_rise;
                d_last_rise = d_cyc;
            end
            d_prev_cs   = cs_n;
            d_prev_sclk = sclk;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        d_cyc = 0; d_last_rise = 0; last_high = 0; period_in = 0;
        rstn = 1'b1; config_start = 1'b0; record_start = 1'b0; zcheck_start = 1'b0;
        tb_tie = 1'b0; tb_loop = 1'b0;
        for (int i = 0; i < 32; i++) off[i] = 8'd0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_stream", data_stream, 0);
        chk("rst_cmd", data_cmd, 0);
        @(posedge clk); #1 rstn = 1'b0;

        // CONFIG with loopback on port A, simultaneous record request loses
        tb_tie = 1'b1; tb_loop = 1'b1;
        for (int i = 0; i < 32; i++) off[i] = 8'd4;
        off[1] = 8'd8;
        for (int f = 0; f < 31; f++) push_frame(cfg_cmd(f), cfg_cmd(f), cfg_cmd(f) << 1, 16'hFFFF);
        q_frames.delete(); q_low.delete();
        @(posedge clk); #1 config_start = 1'b1; record_start = 1'b1;
        @(posedge clk); #1 config_start = 1'b0; record_start = 1'b0;
        @(negedge clk);
        chk("cfg_busy_start", busy, 1);
        chk("cfg_cs_low_start", cs_n, 0);
        repeat (500) @(posedge clk);
        pulse(1);
        wait_idle(6000);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("cfg_nframes", q_frames.size(), 31);
        chk("cfg_frame0", q_frames[0], 16'hFF00);
        chk("cfg_frame3", q_frames[3], 16'h80DE);
        chk("cfg_frame21", q_frames[21], 16'h5500);
        chk("cfg_frame30", q_frames[30], 16'hFF00);
        chk("cfg_cs_low_len", q_low[0], 128);
        chk("cfg_cs_high_len", last_high, 24);
        chk("cfg_busy_end", busy, 0);
        chk("cfg_sb_drained", sb.size(), 0);

        // RECORD: offset 200 clamps to 23, other words offset 0 with miso high
        for (int i = 0; i < 32; i++) off[i] = 8'd0;
        off[0] = 8'd200; off[1] = 8'd23;
        for (int f = 0; f < 36; f++) push_frame(rec_cmd(f), rec_cmd(f) << 3, rec_cmd(f) << 3, 16'hFFFF);
        q_frames.delete(); q_low.delete();
        pulse(1);
        wait_frames(36, 36 * 152 + 400);
        repeat (84) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1 rstn = 1'b0;
        @(negedge clk);
        chk("rec_rst_cs_n", cs_n, 1);
        chk("rec_rst_sclk", sclk, 0);
        chk("rec_rst_busy", busy, 0);
        chk("rec_rst_valid", data_valid, 0);
        chk("rec_frame0", q_frames[0], 16'h0000);
        chk("rec_frame1", q_frames[1], 16'h0100);
        chk("rec_frame34", q_frames[34], 16'hFF00);
        chk("rec_frame35", q_frames[35], 16'h0000);
        chk("rec_cs_low_len", q_low[5], 128);
        chk("rec_cs_high_len", last_high, 24);
        chk("rec_sclk_period", period_in, 8);
        chk("rec_sb_drained", sb.size(), 0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("rec_stays_idle", busy, 0);
        chk("rec_no_more_frames", q_frames.size(), 36);

        // ZCHECK: all MISO low
        tb_tie = 1'b0; tb_loop = 1'b0;
        for (int i = 0; i < 32; i++) off[i] = 8'd5;
        for (int f = 0; f < 66; f++) push_frame(z_cmd(f), 16'h0000, 16'h0000, 16'h0000);
        q_frames.delete(); q_low.delete();
        pulse(2);
        wait_idle(66 * 152 + 400);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("z_nframes", q_frames.size(), 66);
        chk("z_frame0", q_frames[0], 16'h8541);
        chk("z_frame1", q_frames[1], 16'h8700);
        chk("z_frame2", q_frames[2], 16'h0000);
        chk("z_frame3", q_frames[3], 16'h8701);
        chk("z_frame63", q_frames[63], 16'h871F);
        chk("z_frame64", q_frames[64], 16'h1F00);
        chk("z_frame65", q_frames[65], 16'h8500);
        chk("z_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
